handshake_tx_ctrl: RTL and testbench
====================================

HANDSHAKE_TX_CTRL -- requirements
Module: handshake_tx_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the payload width in bits.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4 (power of two, >=2), giving the staging FIFO entries.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 4 (>=1), giving the number of cycles hs_valid is held low between words.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 1024 (>=2), giving the number of REQ cycles allowed before abort.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: upstream word offered.
REQ-008 The block SHALL have port in_data, input, DATA_WIDTH bits: upstream word.
REQ-009 The block SHALL have port in_ready, output, 1 bit: FIFO can accept a word.
REQ-010 The block SHALL have port hs_valid, output, 1 bit: level request to the CDC receiver (tx_valid side).
REQ-011 The block SHALL have port hs_data, output, DATA_WIDTH bits: payload held for the CDC receiver.
REQ-012 The block SHALL have port hs_ready, input, 1 bit: single-cycle acknowledge pulse returned from the CDC (tx_ready).
REQ-013 The block SHALL have port busy, output, 1 bit: high when state != IDLE or the FIFO is non-empty.
REQ-014 The block SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.
REQ-015 The block SHALL have port timeout_err, output, 1 bit: sticky flag set on acknowledge timeout.

Function
REQ-016 in_ready SHALL equal (fifo_count != FIFO_DEPTH), derived from registered count only, so a same-cycle pop does not unblock a full FIFO.
REQ-017 A word SHALL be written into the FIFO on every rising edge with in_valid & in_ready.
REQ-018 The FSM SHALL have three states (IDLE, REQ, GAP) and SHALL reset to IDLE.
REQ-019 IDLE->REQ SHALL occur when the FIFO is non-empty; at that edge hs_data loads the FIFO head and hs_valid becomes 1 (registered).
REQ-020 A word accepted at edge k into an empty FIFO in IDLE SHALL produce hs_valid=1 after edge k+1.
REQ-021 In REQ, hs_valid and hs_data SHALL remain constant until exit.
REQ-022 In REQ, hs_ready=1 SHALL pop the FIFO, drive hs_valid to 0, and move to GAP on that edge.
REQ-023 In REQ, a cycle counter SHALL start at 0 on entry; when it reaches TIMEOUT_CYCLES-1 without hs_ready, the block SHALL set timeout_err, pop (discard) the word, drive hs_valid to 0, and enter GAP.
REQ-024 If hs_ready arrives in the same cycle the timeout expires, the acknowledge SHALL win and timeout_err SHALL NOT be set.
REQ-025 hs_ready SHALL be ignored in IDLE and GAP.
REQ-026 GAP SHALL last exactly GAP_CYCLES cycles with hs_valid=0 and hs_data unchanged; it then goes to REQ if the FIFO is non-empty, otherwise to IDLE.
REQ-027 Word order on hs_data SHALL equal acceptance order on in_data; no word is duplicated, and none is dropped except on timeout.
REQ-028 Push and pop in the same cycle SHALL leave fifo_count unchanged, with read/write pointers wrapping modulo FIFO_DEPTH.

Reset
REQ-029 While rst=1 at a rising edge, the block SHALL set: state=IDLE, FIFO empty, fifo_count=0, in_ready=1 on the following cycle, hs_valid=0, hs_data=0, busy=0, timeout_err=0, and all counters to 0.
REQ-030 Reset asserted mid-REQ or mid-GAP SHALL discard all buffered words and the in-flight word without emitting any further hs_valid pulse.
REQ-031 timeout_err SHALL clear only on reset.

Structure
REQ-032 The FSM state encodings and the default GAP/TIMEOUT values SHALL be defined in the shared generate_parameter.vh header.
REQ-033 The FIFO SHALL be a separate sub-module, sync_fifo (parameters DATA_WIDTH and DEPTH; ports push, pop, wdata, rdata, count).

Verification
REQ-034 After reset, push a single word 0xA5A5_0001 -> hs_valid=1 two edges later with hs_data=0xA5A5_0001; hs_ready pulse 10 cycles later -> hs_valid=0 and 4 low cycles, then IDLE with busy=0.
REQ-035 Push 6 words back-to-back with FIFO_DEPTH=4 and no ack -> in_ready low after the 4th word (5th word stalled); ack each word -> all 6 delivered in order.
REQ-036 Hold hs_ready=0 for 1024 REQ cycles -> timeout_err=1, word popped, next word presented after GAP.
REQ-037 hs_ready pulsed during GAP and IDLE -> no pop, fifo_count and state unchanged.
REQ-038 Assert rst for 1 cycle while in REQ with 3 words queued -> hs_valid=0, fifo_count=0, and no hs_valid for 20 cycles afterwards.
REQ-039 FIFO full, with a push attempt and an ack in the same cycle -> push refused, fifo_count becomes 3, in_ready=1 on the next cycle.

Source files
------------

// File: rtl/handshake_tx_ctrl_pkg.sv
// Shared definitions for the handshake transmit controller: FSM state encoding,
// default timing parameters and a small elaboration helper.
package handshake_tx_ctrl_pkg;

   localparam int DEFAULT_DATA_WIDTH     = 32;
   localparam int DEFAULT_FIFO_DEPTH     = 4;
   localparam int DEFAULT_GAP_CYCLES     = 4;
   localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_GAP  = 2'b10
   } tx_state_e;

   // Sizes the shared REQ/GAP cycle counter from whichever window is longer.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/handshake_tx_ctrl_if.sv
// Upstream valid/ready channel plus the level request/acknowledge channel toward
// the CDC receiver, bundled so the controller and its environment share one view.
interface handshake_tx_ctrl_if #(
   parameter int DATA_WIDTH = handshake_tx_ctrl_pkg::DEFAULT_DATA_WIDTH
);

   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_ready;
   logic                  hs_valid;
   logic [DATA_WIDTH-1:0] hs_data;
   logic                  hs_ready;

   // Controller side: consumes upstream words, drives the CDC request.
   modport master (
      input  in_valid,
      input  in_data,
      input  hs_ready,
      output in_ready,
      output hs_valid,
      output hs_data
   );

   // Environment side: offers upstream words, returns the CDC acknowledge.
   modport slave (
      output in_valid,
      output in_data,
      output hs_ready,
      input  in_ready,
      input  hs_valid,
      input  hs_data
   );

endinterface

// File: rtl/handshake_tx_ctrl_sync_fifo.sv
// Power-of-two synchronous FIFO with combinational head read and registered
// occupancy count; push when full and pop when empty are ignored.
module sync_fifo
   import handshake_tx_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int DEPTH      = DEFAULT_FIFO_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [DATA_WIDTH-1:0]  wdata,
   output logic [DATA_WIDTH-1:0]  rdata,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign do_push = push && (count != COUNT_FULL);
   assign do_pop  = pop  && (count != '0);
   assign rdata   = mem[rd_ptr];

   // NOTE: the storage array is deliberately not reset; only the pointers and count
   // define validity, and leaving it reset-free lets it map onto plain RAM/regfile.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         // Simultaneous push and pop leaves the occupancy unchanged.
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/handshake_tx_ctrl.sv
// Stages upstream words in a FIFO and presents them one at a time as a level
// request to a CDC receiver, with an inter-word gap and an acknowledge timeout.
module handshake_tx_ctrl
   import handshake_tx_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
   parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
   parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                        clk,
   input  logic                        rst,
   handshake_tx_ctrl_if.master         bus,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        timeout_err
);

   localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int CNT_W  = $clog2(max_int(TIMEOUT_CYCLES, GAP_CYCLES));

   localparam logic [FCNT_W-1:0] FIFO_FULL    = FCNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]  GAP_LAST     = CNT_W'(GAP_CYCLES - 1);

   tx_state_e             state_q;
   tx_state_e             state_d;
   logic [CNT_W-1:0]      cnt_q;
   logic [CNT_W-1:0]      cnt_d;
   logic                  hs_valid_q;
   logic                  hs_valid_d;
   logic [DATA_WIDTH-1:0] hs_data_q;
   logic [DATA_WIDTH-1:0] hs_data_d;
   logic                  timeout_err_q;
   logic                  timeout_err_d;

   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  fifo_nonempty;
   logic [DATA_WIDTH-1:0] fifo_rdata;

   // The in-flight word stays in the FIFO until acknowledged or timed out, and
   // in_ready looks only at the registered count, so a pop never unblocks a push
   // in the same cycle.
   assign bus.in_ready  = (fifo_count != FIFO_FULL);
   assign fifo_push     = bus.in_valid && bus.in_ready;
   assign fifo_nonempty = (fifo_count != '0);

   sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (bus.in_data),
      .rdata (fifo_rdata),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         hs_valid_q    <= 1'b0;
         hs_data_q     <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         hs_valid_q    <= hs_valid_d;
         hs_data_q     <= hs_data_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   // NOTE: every signal assigned here gets a hold/default value first, so no path
   // through the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      hs_valid_d    = hs_valid_q;
      hs_data_d     = hs_data_q;
      timeout_err_d = timeout_err_q;
      fifo_pop      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (fifo_nonempty) begin
               state_d    = ST_REQ;
               hs_valid_d = 1'b1;
               hs_data_d  = fifo_rdata;
               cnt_d      = '0;
            end
         end

         ST_REQ: begin
            // Acknowledge has priority over a timeout expiring in the same cycle.
            if (bus.hs_ready) begin
               fifo_pop   = 1'b1;
               hs_valid_d = 1'b0;
               state_d    = ST_GAP;
               cnt_d      = '0;
            end else if (cnt_q == TIMEOUT_LAST) begin
               fifo_pop      = 1'b1;
               timeout_err_d = 1'b1;
               hs_valid_d    = 1'b0;
               state_d       = ST_GAP;
               cnt_d         = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
               if (fifo_nonempty) begin
                  state_d    = ST_REQ;
                  hs_valid_d = 1'b1;
                  hs_data_d  = fifo_rdata;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d    = ST_IDLE;
            hs_valid_d = 1'b0;
            cnt_d      = '0;
         end
      endcase
   end

   assign bus.hs_valid = hs_valid_q;
   assign bus.hs_data  = hs_data_q;
   assign timeout_err  = timeout_err_q;
   assign busy         = (state_q != ST_IDLE) || fifo_nonempty;

endmodule

// File: tb/tb_handshake_tx_ctrl.sv
// Bench for handshake_tx_ctrl: stimulus tables for the directed scenarios, hand
// sequences for timeout and reset, then random traffic against a queue model.
module tb_handshake_tx_ctrl;

   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int GAP   = 4;
   localparam int TO    = 1024;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rst;
   logic          busy;
   logic [CW-1:0] fifo_count;
   logic          timeout_err;

   handshake_tx_ctrl_if #(.DATA_WIDTH(DW)) bus ();

   handshake_tx_ctrl #(
      .DATA_WIDTH     (DW),
      .FIFO_DEPTH     (DEPTH),
      .GAP_CYCLES     (GAP),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .busy        (busy),
      .fifo_count  (fifo_count),
      .timeout_err (timeout_err)
   );

   typedef struct {
      logic          in_valid;
      logic [DW-1:0] in_data;
      logic          hs_ready;
      logic          exp_valid;
      logic [DW-1:0] exp_data;
      logic [CW-1:0] exp_count;
      logic          exp_ready;
      logic          exp_busy;
   } vec_t;

   vec_t        vecs[$];
   logic [DW-1:0] model_q[$];
   int          n_cmp  = 0;
   int          n_fail = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic v, input logic [DW-1:0] d, input logic r,
                               input logic ev, input logic [DW-1:0] ed, input int ec,
                               input logic er, input logic eb);
      vec_t x;
      x.in_valid  = v;
      x.in_data   = d;
      x.hs_ready  = r;
      x.exp_valid = ev;
      x.exp_data  = ed;
      x.exp_count = CW'(ec);
      x.exp_ready = er;
      x.exp_busy  = eb;
      return x;
   endfunction

   task automatic run_table(input string tag);
      for (int i = 0; i < vecs.size(); i++) begin
         bus.in_valid = vecs[i].in_valid;
         bus.in_data  = vecs[i].in_data;
         bus.hs_ready = vecs[i].hs_ready;
         tick();
         check($sformatf("%s[%0d] hs_valid", tag, i), bus.hs_valid, vecs[i].exp_valid);
         check($sformatf("%s[%0d] hs_data", tag, i), bus.hs_data, vecs[i].exp_data);
         check($sformatf("%s[%0d] fifo_count", tag, i), fifo_count, vecs[i].exp_count);
         check($sformatf("%s[%0d] in_ready", tag, i), bus.in_ready, vecs[i].exp_ready);
         check($sformatf("%s[%0d] busy", tag, i), busy, vecs[i].exp_busy);
      end
      bus.in_valid = 1'b0;
      bus.hs_ready = 1'b0;
      vecs.delete();
   endtask

   task automatic push_word(input logic [DW-1:0] d);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!bus.hs_valid && n < 40) begin
         tick();
         n++;
      end
      check({name, " hs_valid seen"}, bus.hs_valid, 1'b1);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 80) begin
         tick();
         n++;
      end
      check({name, " idle"}, busy, 1'b0);
   endtask

   task automatic ack_once();
      bus.hs_ready = 1'b1;
      tick();
      bus.hs_ready = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   localparam logic [DW-1:0] A = 32'hA5A5_0001;
   logic [DW-1:0] w [6];
   int  n_high;
   int  n_low;
   bit  saw_valid;
   int  req_run;
   int  low_len;
   int  low_busy_run;
   bit  seen_high;
   bit  exp_terr;
   logic v;
   logic r;
   logic [DW-1:0] d;

   initial begin
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.hs_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      check("reset hs_valid", bus.hs_valid, 1'b0);
      check("reset hs_data", bus.hs_data, '0);
      check("reset fifo_count", fifo_count, '0);
      check("reset in_ready", bus.in_ready, 1'b1);
      check("reset busy", busy, 1'b0);
      check("reset timeout_err", timeout_err, 1'b0);

      // Single word: two-edge latency, ack, four gap cycles, ack ignored in GAP/IDLE.
      vecs.push_back(mk(1, A, 0, 0, '0, 1, 1, 1));
      vecs.push_back(mk(0, '0, 0, 1, A, 1, 1, 1));
      for (int i = 0; i < 9; i++) vecs.push_back(mk(0, '0, 0, 1, A, 1, 1, 1));
      vecs.push_back(mk(0, '0, 1, 0, A, 0, 1, 1));
      vecs.push_back(mk(0, '0, 1, 0, A, 0, 1, 1));
      vecs.push_back(mk(0, '0, 0, 0, A, 0, 1, 1));
      vecs.push_back(mk(0, '0, 1, 0, A, 0, 1, 1));
      vecs.push_back(mk(0, '0, 0, 0, A, 0, 1, 0));
      vecs.push_back(mk(0, '0, 1, 0, A, 0, 1, 0));
      vecs.push_back(mk(0, '0, 0, 0, A, 0, 1, 0));
      run_table("single");

      // Six back-to-back words into a depth-4 FIFO, full with push+ack collision.
      for (int i = 0; i < 6; i++) w[i] = 32'h1000_0000 + 32'(i * 17 + 3);
      vecs.push_back(mk(1, w[0], 0, 0, A,    1, 1, 1));
      vecs.push_back(mk(1, w[1], 0, 1, w[0], 2, 1, 1));
      vecs.push_back(mk(1, w[2], 0, 1, w[0], 3, 1, 1));
      vecs.push_back(mk(1, w[3], 0, 1, w[0], 4, 0, 1));
      vecs.push_back(mk(1, w[4], 0, 1, w[0], 4, 0, 1));
      vecs.push_back(mk(1, w[4], 1, 0, w[0], 3, 1, 1));
      vecs.push_back(mk(1, w[4], 0, 0, w[0], 4, 0, 1));
      vecs.push_back(mk(1, w[5], 1, 0, w[0], 4, 0, 1));
      vecs.push_back(mk(1, w[5], 0, 0, w[0], 4, 0, 1));
      vecs.push_back(mk(1, w[5], 0, 1, w[1], 4, 0, 1));
      vecs.push_back(mk(1, w[5], 1, 0, w[1], 3, 1, 1));
      vecs.push_back(mk(1, w[5], 0, 0, w[1], 4, 0, 1));
      vecs.push_back(mk(0, '0,   0, 0, w[1], 4, 0, 1));
      vecs.push_back(mk(0, '0,   0, 0, w[1], 4, 0, 1));
      vecs.push_back(mk(0, '0,   0, 1, w[2], 4, 0, 1));
      run_table("burst");

      for (int i = 2; i < 6; i++) begin
         wait_valid($sformatf("burst drain %0d", i));
         check($sformatf("burst order %0d", i), bus.hs_data, w[i]);
         ack_once();
      end
      wait_idle("burst drain");
      check("burst drained count", fifo_count, '0);

      // Acknowledge on the very last timeout cycle wins over the timeout.
      push_word(32'hBEEF_0024);
      wait_valid("ack at limit");
      bus.hs_ready = 1'b0;
      repeat (TO - 1) tick();
      check("ack at limit still requesting", bus.hs_valid, 1'b1);
      ack_once();
      check("ack at limit hs_valid", bus.hs_valid, 1'b0);
      check("ack at limit timeout_err", timeout_err, 1'b0);
      check("ack at limit count", fifo_count, '0);
      wait_idle("ack at limit");

      // Full timeout: word discarded, sticky error, next word after the gap.
      push_word(32'hDEAD_0001);
      push_word(32'hDEAD_0002);
      wait_valid("timeout");
      check("timeout first word", bus.hs_data, 32'hDEAD_0001);
      check("timeout_err before expiry", timeout_err, 1'b0);
      n_high = 1;
      while (n_high < TO + 50) begin
         tick();
         if (!bus.hs_valid) break;
         n_high++;
      end
      check("timeout request length", n_high, TO);
      check("timeout_err set", timeout_err, 1'b1);
      check("timeout word discarded", fifo_count, 1);
      n_low = 1;
      while (n_low < 40) begin
         tick();
         if (bus.hs_valid) break;
         n_low++;
      end
      check("timeout gap length", n_low, GAP);
      check("timeout next word", bus.hs_data, 32'hDEAD_0002);
      ack_once();
      wait_idle("timeout");
      check("timeout_err sticky", timeout_err, 1'b1);

      // Reset mid-REQ with three words queued.
      push_word(32'h0000_0C01);
      push_word(32'h0000_0C02);
      push_word(32'h0000_0C03);
      wait_valid("reset in REQ");
      pulse_reset();
      check("reset in REQ hs_valid", bus.hs_valid, 1'b0);
      check("reset in REQ hs_data", bus.hs_data, '0);
      check("reset in REQ count", fifo_count, '0);
      check("reset in REQ in_ready", bus.in_ready, 1'b1);
      check("reset in REQ busy", busy, 1'b0);
      check("reset clears timeout_err", timeout_err, 1'b0);
      saw_valid = 1'b0;
      repeat (20) begin
         tick();
         if (bus.hs_valid) saw_valid = 1'b1;
      end
      check("reset in REQ no request afterwards", saw_valid, 1'b0);

      // Reset mid-GAP with one word still queued.
      push_word(32'h0000_0D01);
      push_word(32'h0000_0D02);
      wait_valid("reset in GAP");
      ack_once();
      tick();
      pulse_reset();
      check("reset in GAP count", fifo_count, '0);
      saw_valid = 1'b0;
      repeat (20) begin
         tick();
         if (bus.hs_valid) saw_valid = 1'b1;
      end
      check("reset in GAP no request afterwards", saw_valid, 1'b0);

      // Random traffic against a queue model; the last 80 cycles drain it.
      model_q.delete();
      req_run      = 0;
      low_len      = 0;
      low_busy_run = 0;
      seen_high    = 1'b0;
      exp_terr     = 1'b0;
      for (int cyc = 0; cyc < 3080; cyc++) begin
         check("rand fifo_count", fifo_count, model_q.size());
         check("rand in_ready", bus.in_ready, model_q.size() != DEPTH);
         check("rand timeout_err", timeout_err, exp_terr);
         if (model_q.size() != 0) check("rand busy", busy, 1'b1);
         if (bus.hs_valid) begin
            check("rand request without word", model_q.size() == 0, 1'b0);
            if (model_q.size() != 0) check("rand word order", bus.hs_data, model_q[0]);
            if (seen_high && low_len > 0) check("rand gap too short", low_len >= GAP, 1'b1);
            seen_high = 1'b1;
            low_len   = 0;
         end else begin
            low_len++;
         end
         if (!bus.hs_valid && model_q.size() != 0) low_busy_run++;
         else low_busy_run = 0;
         check("rand request overdue", low_busy_run > GAP, 1'b0);

         if (cyc < 3000) begin
            v = ($urandom_range(0, 2) != 0);
            d = $urandom;
            r = ($urandom_range(0, 3) == 0);
         end else begin
            v = 1'b0;
            d = '0;
            r = 1'b1;
         end
         bus.in_valid = v;
         bus.in_data  = d;
         bus.hs_ready = r;

         if (bus.hs_valid) begin
            if (r) begin
               void'(model_q.pop_front());
            end else if (req_run == TO - 1) begin
               void'(model_q.pop_front());
               exp_terr = 1'b1;
            end
            req_run++;
         end else begin
            req_run = 0;
         end
         if (v && model_q.size() + ((bus.hs_valid && (r || req_run == TO)) ? 1 : 0) != DEPTH)
            model_q.push_back(d);
         tick();
      end
      bus.in_valid = 1'b0;
      bus.hs_ready = 1'b0;
      check("rand drained model", model_q.size(), 0);
      check("rand drained count", fifo_count, '0);
      check("rand drained busy", busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
